multiword_add_sequencer: RTL and testbench
==========================================

Name: multiword_add_sequencer

Overview:
- Multi-cycle wide adder controller: accepts WORDS*WIDTH-bit operands over a valid/ready handshake and issues them one WIDTH-bit word per cycle, LSW first, to an external WIDTH-bit combinational carry-lookahead adder instance.
- Chains each word's carry-out into the next word's carry-in.
- Collects the per-word sums and presents the full-width result, carry-out and signed overflow on a valid/ready output.
- Sits directly around the adder: drives its A/B/Cin and consumes its F/Cout.

Parameters:
- WORDS, 4, number of adder-width words per operand; legal range >= 1.
- WIDTH, 32, width of the attached adder; must match the adder instance.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set offered.
- in_ready  output  1  sequencer can accept operands.
- in_a  input  WORDS*WIDTH  operand A.
- in_b  input  WORDS*WIDTH  operand B.
- in_cin  input  1  carry into word 0.
- add_a  output  WIDTH  to adder A.
- add_b  output  WIDTH  to adder B.
- add_cin  output  1  to adder Cin.
- add_f  input  WIDTH  from adder F, same cycle.
- add_cout  input  1  from adder Cout, same cycle.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WORDS*WIDTH  result.
- out_cout  output  1  carry out of the MSW.
- out_ovf  output  1  two's-complement overflow of the full-width add.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: rst sampled high at a rising clk edge takes effect at that edge.
- States: IDLE, RUN, DONE. Word index idx is a counter of width clog2(WORDS), minimum 1 bit.
- Reset state:
  - state=IDLE, idx=0, carry_reg=0.
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0.
  - add_a, add_b, add_cin = 0.
- in_ready = (state==IDLE), combinational from state only.
- IDLE:
  - On in_valid&&in_ready, latch in_a, in_b and in_cin.
  - Set idx=0 and go to RUN.
  - Operand inputs are not sampled at any other time.
- RUN:
  - add_a = a_reg word idx; add_b = b_reg word idx.
  - add_cin = cin_reg when idx==0, otherwise carry_reg.
  - Each edge: sum_reg word idx <= add_f, carry_reg <= add_cout.
  - When idx==WORDS-1: out_cout <= add_cout, out_ovf <= (a_msb==b_msb)&&(add_f[WIDTH-1]!=a_msb), state <= DONE. Otherwise idx <= idx+1.
  - The adder is combinational, so there is no wait state between words.
- Latency: accept edge at cycle 0 → RUN occupies cycles 1..WORDS → out_valid=1 from cycle WORDS+1. With WORDS=1, RUN lasts one cycle.
- DONE:
  - out_valid=1; out_sum, out_cout and out_ovf held stable.
  - in_ready=0; in_valid is ignored.
  - On out_ready, the handoff completes at that edge: out_valid=0 and state goes to IDLE.
  - A new accept is possible one cycle later; there is no overlap of consecutive operations.
- Outside RUN, add_a, add_b and add_cin are driven 0.
- out_sum equals sum_reg. It is meaningful only while out_valid=1; during RUN it holds partial words.
- Wrap: the carry out of the MSW is reported on out_cout; no extra sum bit is produced.
- Reset in RUN or DONE:
  - Aborts the operation at that edge; state goes to IDLE, out_valid=0 and all registers are cleared.
  - No result is emitted for the aborted operation.
- rst wins over a simultaneous handshake.

Optional Feature:
- Macro: MULTIWORD_ADD_SUB_EN.
- Defined:
  - Adds port in_sub (input, 1 bit), latched with the operands.
  - When in_sub=1: b_reg = ~in_b and the effective carry into word 0 is 1, so in_cin is ignored. Result is A−B.
  - out_cout=1 means no borrow.
  - Overflow is computed using the inverted b_msb.
- Undefined: port absent; add only.

Test Plan (WORDS=4, WIDTH=32):
- rst high for 2 cycles → in_ready=1, out_valid=0, out_sum=0, out_cout=0, add_a=add_b=0.
- Carry ripple: a=128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, b=1, cin=0 → out_valid exactly 5 cycles after the accept edge, out_sum=128'h00000001_00000000_00000000_00000000, out_cout=0, out_ovf=0; add_cin sequence 0,1,1,1.
- Full wrap: a=all ones, b=0, cin=1 → out_sum=0, out_cout=1, out_ovf=0.
- Signed overflow: a=128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, b=1, cin=0 → out_sum=128'h80000000_00000000_00000000_00000000, out_cout=0, out_ovf=1.
- Backpressure plus reset:
  - Hold out_ready=0 for 10 cycles in DONE → out_valid stays 1, outputs stable, in_ready=0, a pulsed in_valid is not accepted.
  - Separately, assert rst while idx==2 → IDLE next cycle, out_valid never rises, and a following add of 3+4 returns out_sum=7.
- MULTIWORD_ADD_SUB_EN build only: a=5, b=7, in_sub=1 → out_sum=128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, out_cout=0, out_ovf=0. Then a=7, b=5 → out_sum=2, out_cout=1.

Source files
------------

// File: rtl/multiword_add_sequencer.sv
// Sequences a WORDS*WIDTH-bit add through an external WIDTH-bit adder, LSW first, with carry chaining.
// Optional subtract mode is enabled by defining MULTIWORD_ADD_SUB_EN.
module multiword_add_sequencer #(
  parameter int unsigned WORDS = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORDS*WIDTH-1:0]   in_a,
  input  logic [WORDS*WIDTH-1:0]   in_b,
  input  logic                     in_cin,
`ifdef MULTIWORD_ADD_SUB_EN
  input  logic                     in_sub,
`endif
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_cin,
  input  logic [WIDTH-1:0]         add_f,
  input  logic                     add_cout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORDS*WIDTH-1:0]   out_sum,
  output logic                     out_cout,
  output logic                     out_ovf
);

  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        carry_q, carry_d;
  logic                        cin_q, cin_d;
  logic [WORDS-1:0][WIDTH-1:0] a_q, a_d;
  logic [WORDS-1:0][WIDTH-1:0] b_q, b_d;
  logic [WORDS-1:0][WIDTH-1:0] sum_q, sum_d;
  logic                        cout_q, cout_d;
  logic                        ovf_q, ovf_d;
  logic                        out_valid_q, out_valid_d;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

  // Adder operands: current word while running, quiet zero otherwise.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == S_RUN) begin
      add_a   = a_q[idx_q];
      add_b   = b_q[idx_q];
      add_cin = (idx_q == '0) ? cin_q : carry_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    cin_d       = cin_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d = in_a;
`ifdef MULTIWORD_ADD_SUB_EN
          // Subtract as A + ~B + 1; the stored inverted B also feeds the overflow sign test.
          b_d   = in_sub ? ~in_b : in_b;
          cin_d = in_sub ? 1'b1 : in_cin;
`else
          b_d   = in_b;
          cin_d = in_cin;
`endif
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[idx_q] = add_f;
        carry_d      = add_cout;
        if (idx_q == IDX_LAST) begin
          cout_d      = add_cout;
          ovf_d       = (a_q[WORDS-1][WIDTH-1] == b_q[WORDS-1][WIDTH-1]) &&
                        (add_f[WIDTH-1] != a_q[WORDS-1][WIDTH-1]);
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cin_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      cin_q       <= cin_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Bench for multiword_add_sequencer: full-width arithmetic model checked every cycle plus directed literal cases.
module tb_multiword_add_sequencer;

  localparam int WORDS = 4;
  localparam int WIDTH = 32;
  localparam int TOT   = WORDS * WIDTH;
`ifdef MULTIWORD_ADD_SUB_EN
  localparam logic SUB_EN = 1'b1;
`else
  localparam logic SUB_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [TOT-1:0]   in_a;
  logic [TOT-1:0]   in_b;
  logic             in_cin;
  logic             in_sub;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_f;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready;
  logic [TOT-1:0]   out_sum;
  logic             out_cout;
  logic             out_ovf;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  multiword_add_sequencer #(.WORDS(WORDS), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef MULTIWORD_ADD_SUB_EN
    .in_sub(in_sub),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_f(add_f), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  // External combinational adder.
  assign {add_cout, add_f} = {1'b0, add_a} + {1'b0, add_b} + (WIDTH+1)'(add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [TOT-1:0] act, input logic [TOT-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: whole-operation arithmetic plus a cycle count since accept.
  wire             sub_s  = in_sub & SUB_EN;
  wire [TOT-1:0]   eff_b  = sub_s ? ~in_b : in_b;
  wire             eff_c  = sub_s ? 1'b1 : in_cin;
  wire [TOT:0]     full_w = {1'b0, in_a} + {1'b0, eff_b} + (TOT+1)'(eff_c);

  logic           m_busy = 1'b0;
  logic           m_done = 1'b0;
  int             m_cnt  = 0;
  logic [TOT-1:0] m_a, m_b, m_sum;
  logic           m_cin, m_cout, m_ovf;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else if (m_done) begin
      if (out_ready) m_done <= 1'b0;
    end else if (m_busy) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == WORDS) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end
    end else if (in_valid) begin
      m_a    <= in_a;
      m_b    <= eff_b;
      m_cin  <= eff_c;
      m_sum  <= full_w[TOT-1:0];
      m_cout <= full_w[TOT];
      m_ovf  <= (in_a[TOT-1] == eff_b[TOT-1]) && (full_w[TOT-1] != in_a[TOT-1]);
      m_cnt  <= 0;
      m_busy <= 1'b1;
    end
  end

  // Carry entering word k of the model's operation, from a plain add of the lower k words.
  function automatic logic carry_into(input int k);
    logic [TOT:0] mask, t;
    if (k == 0) return m_cin;
    mask = ((TOT+1)'(1) << (k * WIDTH)) - (TOT+1)'(1);
    t    = ({1'b0, m_a} & mask) + ({1'b0, m_b} & mask) + (TOT+1)'(m_cin);
    return t[k * WIDTH];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_in_ready", TOT'(in_ready), TOT'(!m_busy && !m_done));
      chk("m_out_valid", TOT'(out_valid), TOT'(m_done));
      if (m_done) begin
        chk("m_out_sum", out_sum, m_sum);
        chk("m_out_cout", TOT'(out_cout), TOT'(m_cout));
        chk("m_out_ovf", TOT'(out_ovf), TOT'(m_ovf));
      end
      if (m_busy) begin
        chk("m_add_a", TOT'(add_a), TOT'(m_a[m_cnt*WIDTH +: WIDTH]));
        chk("m_add_b", TOT'(add_b), TOT'(m_b[m_cnt*WIDTH +: WIDTH]));
        chk("m_add_cin", TOT'(add_cin), TOT'(carry_into(m_cnt)));
      end else begin
        chk("m_add_idle", TOT'({add_a, add_b, add_cin}), '0);
      end
    end
  end

  // One operation with hand-computed expectations; hold>0 keeps out_ready low in DONE.
  task automatic run_op(input logic [TOT-1:0] a, input logic [TOT-1:0] b, input logic cin,
                        input logic sub, input logic [TOT-1:0] es, input logic ec, input logic eo,
                        input logic [WORDS-1:0] ecin_seq, input int hold);
    int n;
    logic [WORDS-1:0] cin_seq;
    cin_seq = '0;
    @(posedge clk); #1;
    chk("op_ready_before", TOT'(in_ready), TOT'(1));
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = ~a; in_b = ~b; in_cin = ~cin; in_sub = ~sub;
    n = 0;
    while (!out_valid && n < 20) begin
      if (n < WORDS) cin_seq[n] = add_cin;
      @(posedge clk); #1;
      n++;
    end
    chk("op_latency", TOT'(n), TOT'(WORDS));
    chk("op_cin_seq", TOT'(cin_seq), TOT'(ecin_seq));
    chk("op_sum", out_sum, es);
    chk("op_cout", TOT'(out_cout), TOT'(ec));
    chk("op_ovf", TOT'(out_ovf), TOT'(eo));
    for (int i = 0; i < hold; i++) begin
      in_valid = (i == 3);
      in_a = 128'h1111; in_b = 128'h2222;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_valid", TOT'(out_valid), TOT'(1));
      chk("bp_ready", TOT'(in_ready), TOT'(0));
      chk("bp_sum", out_sum, es);
      chk("bp_flags", TOT'({out_cout, out_ovf}), TOT'({ec, eo}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("op_handoff_valid", TOT'(out_valid), TOT'(0));
    chk("op_handoff_ready", TOT'(in_ready), TOT'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", TOT'(in_ready), TOT'(1));
    chk("rst_out_valid", TOT'(out_valid), TOT'(0));
    chk("rst_out_sum", out_sum, '0);
    chk("rst_out_flags", TOT'({out_cout, out_ovf}), '0);
    chk("rst_add", TOT'({add_a, add_b, add_cin}), '0);
    rst = 1'b0;
    chk_en = 1'b1;

    run_op(128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0, 1'b0,
           128'h00000001_00000000_00000000_00000000, 1'b0, 1'b0, 4'b1110, 0);
    run_op({TOT{1'b1}}, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0, 4'b1111, 0);
    run_op(128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0, 1'b0,
           128'h80000000_00000000_00000000_00000000, 1'b0, 1'b1, 4'b1110, 10);

    // Abort while word 2 is on the adder.
    @(posedge clk); #1;
    in_a = 128'h44444444_33333333_22222222_11111111;
    in_b = 128'h88888888_77777777_66666666_55555555;
    in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_idx2_add_a", TOT'(add_a), TOT'(32'h33333333));
    chk("abort_idx2_add_b", TOT'(add_b), TOT'(32'h77777777));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", TOT'(in_ready), TOT'(1));
    chk("abort_out_valid", TOT'(out_valid), TOT'(0));
    chk("abort_sum_cleared", out_sum, '0);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_result", TOT'(seen), '0);

    run_op(128'h3, 128'h4, 1'b0, 1'b0, 128'h7, 1'b0, 1'b0, 4'b0000, 0);

`ifdef MULTIWORD_ADD_SUB_EN
    run_op(128'h5, 128'h7, 1'b0, 1'b1,
           128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 1'b0, 1'b0, 4'b0001, 0);
    run_op(128'h7, 128'h5, 1'b0, 1'b1, 128'h2, 1'b1, 1'b0, 4'b1111, 0);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
